// File: rtl/serial_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx_ctrl
// Brief    : Parallel-to-serial transmit stage (valid/ready in, bit-serial out).
//            Optional even-parity trailer bit when PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module serial_tx_ctrl #(
   parameter int W     = 8,
   parameter int CNT_W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   input  logic         lsb_first,
   output logic         s_out,
   output logic         s_valid,
   input  logic         s_ready,
   output logic         busy,
   output logic         done
);

`ifdef PARITY_EN
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_PAR   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd3
   } state_t;
`endif

   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(W - 1);
   localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

   state_t           state_q, state_d;
   logic [W-1:0]     sr_q,    sr_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             dir_q,   dir_d;
`ifdef PARITY_EN
   logic             par_q,   par_d;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
`ifdef PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
`ifdef PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      sr_d     = sr_q;
      cnt_d    = cnt_q;
      dir_d    = dir_q;
`ifdef PARITY_EN
      par_d    = par_q;
`endif
      in_ready = 1'b0;
      s_valid  = 1'b0;
      s_out    = 1'b0;
      busy     = 1'b1;
      done     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            // in_ready is 1 throughout IDLE, so in_valid alone marks an accept
            if (in_valid) begin
               sr_d    = in_data;
               dir_d   = lsb_first;
               cnt_d   = '0;
`ifdef PARITY_EN
               par_d   = ^in_data;
`endif
               state_d = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            s_valid = 1'b1;
            s_out   = dir_q ? sr_q[0] : sr_q[W-1];
            if (s_ready) begin
               sr_d  = dir_q ? {1'b0, sr_q[W-1:1]} : {sr_q[W-2:0], 1'b0};
               cnt_d = cnt_q + C_ONE;
               if (cnt_q == C_LAST) begin
`ifdef PARITY_EN
                  state_d = ST_PAR;
`else
                  state_d = ST_DONE;
`endif
               end
            end
         end

`ifdef PARITY_EN
         ST_PAR: begin
            s_valid = 1'b1;
            s_out   = par_q;
            if (s_ready) begin
               state_d = ST_DONE;
            end
         end
`endif

         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_tx_ctrl
// Brief    : Directed self-checking bench for serial_tx_ctrl (W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_tx_ctrl;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       lsb_first;
   logic       s_out;
   logic       s_valid;
   logic       s_ready;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;

   serial_tx_ctrl #(.W(8), .CNT_W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .lsb_first (lsb_first),
      .s_out     (s_out),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input logic [7:0] data, input logic lsb);
      in_data   = data;
      lsb_first = lsb;
      in_valid  = 1'b1;
      step();
      in_valid  = 1'b0;
   endtask

   // seq[i] is the i-th bit expected on the wire.
   task automatic run_beats(input string tag, input logic [7:0] seq,
                            input int stall_idx, input int toggle_idx);
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (s_valid !== 1'b1 || s_out !== seq[i] || in_ready !== 1'b0 ||
             busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s beat%0d: got s_valid=%b s_out=%b in_ready=%b busy=%b done=%b, expected 1 %b 0 1 0",
                     tag, i, s_valid, s_out, in_ready, busy, done, seq[i]);
         end
         if (i == toggle_idx) lsb_first = ~lsb_first;
         if (i == stall_idx) begin
            s_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
               step();
               n_checks++;
               if (s_valid !== 1'b1 || s_out !== seq[i] || done !== 1'b0) begin
                  n_fail++;
                  $display("FAIL %s stall%0d: got s_valid=%b s_out=%b done=%b, expected 1 %b 0",
                           tag, k, s_valid, s_out, done, seq[i]);
               end
            end
            s_ready = 1'b1;
         end
         step();
      end
   endtask

`ifdef PARITY_EN
   task automatic check_parity(input string tag, input logic par);
      n_checks++;
      if (s_valid !== 1'b1 || s_out !== par || done !== 1'b0) begin
         n_fail++;
         $display("FAIL %s parity: got s_valid=%b s_out=%b done=%b, expected 1 %b 0",
                  tag, s_valid, s_out, done, par);
      end
      step();
   endtask
`endif

   task automatic check_done(input string tag);
      n_checks++;
      if (done !== 1'b1 || s_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL %s done: got done=%b s_valid=%b in_ready=%b busy=%b, expected 1 0 0 1",
                  tag, done, s_valid, in_ready, busy);
      end
      step();
      n_checks++;
      if (done !== 1'b0 || s_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s idle: got done=%b s_valid=%b in_ready=%b busy=%b, expected 0 0 1 0",
                  tag, done, s_valid, in_ready, busy);
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'hFF;
      lsb_first = 1'b1;
      s_ready   = 1'b1;
      step();
      step();
      n_checks++;
      if (in_ready !== 1'b1 || s_valid !== 1'b0 || s_out !== 1'b0 ||
          busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: got in_ready=%b s_valid=%b s_out=%b busy=%b done=%b, expected 1 0 0 0 0",
                  in_ready, s_valid, s_out, busy, done);
      end
      reset    = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic test_lsb_first();
      start_frame(8'hA5, 1'b1);
      run_beats("lsbA5", 8'hA5, -1, -1);
`ifdef PARITY_EN
      check_parity("lsbA5", 1'b0);
`endif
      check_done("lsbA5");
   endtask

   task automatic test_msb_first();
      start_frame(8'hA5, 1'b0);
      run_beats("msbA5", 8'hA5, -1, -1);
`ifdef PARITY_EN
      check_parity("msbA5", 1'b0);
`endif
      check_done("msbA5");
      start_frame(8'h80, 1'b0);
      run_beats("msb80", 8'h01, -1, -1);
`ifdef PARITY_EN
      check_parity("msb80", 1'b1);
`endif
      check_done("msb80");
   endtask

   task automatic test_stall();
      start_frame(8'h3C, 1'b1);
      run_beats("stall3C", 8'h3C, 2, -1);
`ifdef PARITY_EN
      check_parity("stall3C", 1'b0);
`endif
      check_done("stall3C");
   endtask

   task automatic test_back_to_back();
      in_data   = 8'h01;
      lsb_first = 1'b1;
      in_valid  = 1'b1;
      step();
      in_data = 8'hFF;
      run_beats("b2b01", 8'h01, -1, 3);
`ifdef PARITY_EN
      check_parity("b2b01", 1'b1);
`endif
      check_done("b2b01");
      step();
      in_valid = 1'b0;
      run_beats("b2bFF", 8'hFF, -1, -1);
`ifdef PARITY_EN
      check_parity("b2bFF", 1'b0);
`endif
      check_done("b2bFF");
   endtask

   task automatic test_reset_midframe();
      start_frame(8'hF0, 1'b1);
      for (int i = 0; i < 3; i++) step();
      n_checks++;
      if (s_valid !== 1'b1 || s_out !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst bit3: got s_valid=%b s_out=%b, expected 1 0", s_valid, s_out);
      end
      reset = 1'b1;
      step();
      n_checks++;
      if (s_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 ||
          done !== 1'b0 || s_out !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst: got s_valid=%b busy=%b in_ready=%b done=%b s_out=%b, expected 0 0 1 0 0",
                  s_valid, busy, in_ready, done, s_out);
      end
      reset = 1'b0;
      step();
      n_checks++;
      if (done !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst after: got done=%b in_ready=%b, expected 0 1", done, in_ready);
      end
      start_frame(8'h0F, 1'b1);
      run_beats("post0F", 8'h0F, -1, -1);
`ifdef PARITY_EN
      check_parity("post0F", 1'b0);
`endif
      check_done("post0F");
   endtask

   task automatic test_frame_length();
      start_frame(8'h07, 1'b1);
      run_beats("len07", 8'h07, -1, -1);
`ifdef PARITY_EN
      check_parity("len07", 1'b1);
`endif
      check_done("len07");
      start_frame(8'h03, 1'b1);
      run_beats("len03", 8'h03, -1, -1);
`ifdef PARITY_EN
      check_parity("len03", 1'b0);
`endif
      check_done("len03");
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      lsb_first = 1'b0;
      s_ready   = 1'b0;
      #1;
      test_reset();
      test_lsb_first();
      test_msb_first();
      test_stall();
      test_back_to_back();
      test_reset_midframe();
      test_frame_length();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
